// File: rtl/port_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : port_display_scanner
//  Description : Time-multiplexed four-digit common-anode seven-segment driver.
//                Captures three port bytes into a shadow register once per
//                frame so the displayed value never tears mid-scan. The
//                optional leading-zero blanking is compiled in when the
//                macro LEADING_ZERO_BLANK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module port_display_scanner #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] digits_lo,
    input  logic [7:0] digits_hi,
    input  logic [7:0] control,
    output logic [3:0] anode,
    output logic [6:0] segment,
    output logic       dp,
    output logic       frame_tick
);

    localparam int c_pw = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_pw-1:0] c_p_last  = c_pw'(CLK_DIV - 1);
    localparam logic [c_pw-1:0] c_p_blank = c_pw'(BLANK_CYCLES);

    // Scan position and shadow copy of {control, digits_hi, digits_lo}
    logic [c_pw-1:0] p_q, p_d;
    logic [1:0]      i_q, i_d;
    logic [23:0]     shadow_q, shadow_d;

    // Registered display outputs
    logic [3:0]      anode_q, anode_d;
    logic [6:0]      segment_q, segment_d;
    logic            dp_q, dp_d;
    logic            frame_tick_q, frame_tick_d;

    // Combinational helpers
    logic            w_load;
    logic [3:0]      w_nibble;
    logic            w_en;
    logic            w_dp;
    logic [6:0]      w_pattern;
    logic [3:0]      w_lz_blank;
    logic            w_past_blank;
    logic            w_visible;

    // Prescaler, digit index and once-per-frame shadow capture
    always_comb begin
        w_load   = (p_q == '0) && (i_q == 2'd0);
        p_d      = p_q + c_pw'(1);
        i_d      = i_q;
        shadow_d = shadow_q;
        if (p_q == c_p_last) begin
            p_d = '0;
            i_d = i_q + 2'd1;
        end
        if (w_load) begin
            shadow_d = {control, digits_hi, digits_lo};
        end
    end

    // Select the current digit's nibble, decimal point and enable from the shadow
    always_comb begin
        w_nibble = shadow_q[3:0];
        w_dp     = shadow_q[16];
        w_en     = shadow_q[20];
        case (i_q)
            2'd0: begin w_nibble = shadow_q[3:0];   w_dp = shadow_q[16]; w_en = shadow_q[20]; end
            2'd1: begin w_nibble = shadow_q[7:4];   w_dp = shadow_q[17]; w_en = shadow_q[21]; end
            2'd2: begin w_nibble = shadow_q[11:8];  w_dp = shadow_q[18]; w_en = shadow_q[22]; end
            default: begin w_nibble = shadow_q[15:12]; w_dp = shadow_q[19]; w_en = shadow_q[23]; end
        endcase
    end

    // Hex to gfedcba segment pattern, active-high
    always_comb begin
        w_pattern = 7'h00;
        case (w_nibble)
            4'h0: w_pattern = 7'h3F;
            4'h1: w_pattern = 7'h06;
            4'h2: w_pattern = 7'h5B;
            4'h3: w_pattern = 7'h4F;
            4'h4: w_pattern = 7'h66;
            4'h5: w_pattern = 7'h6D;
            4'h6: w_pattern = 7'h7D;
            4'h7: w_pattern = 7'h07;
            4'h8: w_pattern = 7'h7F;
            4'h9: w_pattern = 7'h6F;
            4'hA: w_pattern = 7'h77;
            4'hB: w_pattern = 7'h7C;
            4'hC: w_pattern = 7'h39;
            4'hD: w_pattern = 7'h5E;
            4'hE: w_pattern = 7'h79;
            default: w_pattern = 7'h71;
        endcase
    end

    // Leading-zero suppression: a digit is blank when it and every higher digit are zero
    always_comb begin
        w_lz_blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        w_lz_blank[3] = (shadow_q[15:12] == 4'h0);
        w_lz_blank[2] = w_lz_blank[3] && (shadow_q[11:8] == 4'h0);
        w_lz_blank[1] = w_lz_blank[2] && (shadow_q[7:4] == 4'h0);
        w_lz_blank[0] = 1'b0;
`endif
    end

    // Render next output state; anodes stay off during the anti-ghost window
    always_comb begin
        w_past_blank = (BLANK_CYCLES == 0) ? 1'b1 : (p_q >= c_p_blank);
        w_visible    = w_past_blank && w_en && !w_lz_blank[i_q];
        anode_d      = 4'b1111;
        segment_d    = 7'h7F;
        dp_d         = 1'b1;
        frame_tick_d = w_load;
        if (w_visible) begin
            anode_d   = ~(4'b0001 << i_q);
            segment_d = ~w_pattern;
            dp_d      = ~w_dp;
        end
    end

    // State register; an active-low reset aborts the scan on the same edge
    always_ff @(posedge clock) begin
        if (!reset) begin
            p_q          <= '0;
            i_q          <= 2'd0;
            shadow_q     <= 24'h000000;
            anode_q      <= 4'b1111;
            segment_q    <= 7'h7F;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            i_q          <= i_d;
            shadow_q     <= shadow_d;
            anode_q      <= anode_d;
            segment_q    <= segment_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anode      = anode_q;
    assign segment    = segment_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
